// File: rtl/vme_system_arbiter.sv
// VME slot-1 system controller: four-level bus arbiter driving the BG daisy-chain
// heads, BCLR request to lower-priority owners, and the data-transfer bus timer.
// All VME-side signals are active-low.
module vme_system_arbiter #(
  parameter int ROUND_ROBIN   = 0,
  parameter int GRANT_TIMEOUT = 64,
  parameter int BUS_TIMEOUT   = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sys_con,
  input  logic [3:0] vme_bus_request,
  input  logic       vme_bbsy,
  input  logic       vme_as,
  input  logic       vme_dtack,
  input  logic       vme_berr_in,
  output logic [3:0] vme_bus_grant_out,
  output logic       vme_bclr,
  output logic       vme_berr_out,
  output logic [1:0] owner_level
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, SETTLE} state_t;

  localparam logic [7:0]  GNT_TOP = 8'(GRANT_TIMEOUT - 1);
  localparam logic [15:0] BT_TOP  = 16'(BUS_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  gnt_cnt;
  logic [15:0] bt_cnt;
  logic [1:0]  last_level;
  logic [1:0]  sel_level;
  logic [1:0]  rr_idx;
  logic        higher_req;
  logic        bt_run;

  // Pick the level to grant next from the current request pattern
  always_comb begin
    sel_level = '0;
    rr_idx    = '0;
    if (ROUND_ROBIN != 0) begin
      // Scan from the farthest offset inward so the nearest level after
      // last_level wins; offset 4 (last_level itself) only survives if alone.
      for (int unsigned k = 4; k >= 1; k--) begin
        rr_idx = last_level + k[1:0];
        if (!vme_bus_request[rr_idx]) sel_level = rr_idx;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        if (!vme_bus_request[i[1:0]]) sel_level = i[1:0];
    end
  end

  // A request above the current owner's level warrants a bus-clear (fixed priority only)
  always_comb begin
    higher_req = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      if (!vme_bus_request[i[1:0]] && (i > 32'(last_level)))
        higher_req = (ROUND_ROBIN == 0);
  end

  // Bus timer runs only while a strobed cycle has no DTACK/BERR response
  always_comb bt_run = !vme_as && vme_dtack && vme_berr_in;

  // Arbitration FSM with registered grant/bclr/owner outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      vme_bus_grant_out <= '1;
      vme_bclr          <= 1'b1;
      owner_level       <= '0;
      gnt_cnt           <= '0;
      last_level        <= '0;
    end else if (sys_con) begin
      state             <= IDLE;
      vme_bus_grant_out <= '1;
      vme_bclr          <= 1'b1;
      owner_level       <= '0;
      gnt_cnt           <= '0;
      last_level        <= '0;
    end else begin
      case (state)
        IDLE: begin
          vme_bus_grant_out <= '1;
          vme_bclr          <= 1'b1;
          if ((vme_bus_request != 4'b1111) && vme_bbsy) begin
            owner_level                  <= sel_level;
            vme_bus_grant_out            <= '1;
            vme_bus_grant_out[sel_level] <= 1'b0;
            gnt_cnt                      <= '0;
            state                        <= GRANT;
          end
        end
        GRANT: begin
          gnt_cnt <= gnt_cnt + 8'd1;
          if (!vme_bbsy) begin
            vme_bus_grant_out <= '1;
            last_level        <= owner_level;
            state             <= BUSY;
          end else if (vme_bus_request[owner_level] || (gnt_cnt == GNT_TOP)) begin
            vme_bus_grant_out <= '1;
            state             <= SETTLE;
          end
        end
        BUSY: begin
          if (vme_bbsy) begin
            vme_bclr <= 1'b1;
            state    <= SETTLE;
          end else begin
            vme_bclr <= !higher_req;
          end
        end
        SETTLE: begin
          vme_bus_grant_out <= '1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus timer: saturates at the top value so its own BERR holds until AS releases
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bt_cnt       <= '0;
      vme_berr_out <= 1'b1;
    end else if (sys_con) begin
      bt_cnt       <= '0;
      vme_berr_out <= 1'b1;
    end else begin
      if (!bt_run)
        bt_cnt <= '0;
      else if (bt_cnt != BT_TOP)
        bt_cnt <= bt_cnt + 16'd1;
      if (vme_as)
        vme_berr_out <= 1'b1;
      else if (bt_run && (bt_cnt == BT_TOP))
        vme_berr_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vme_system_arbiter.sv
// Bench for vme_system_arbiter: one fixed-priority and one round-robin instance
// share the bus stimulus; a behavioural model predicts both every cycle, and
// directed sequences pin grant order, timeouts and bus-timer latency.
module tb_vme_system_arbiter;

  localparam int GT = 8;
  localparam int BT = 16;
  localparam logic [3:0] F = 4'b1111;

  logic       clock = 1'b0;
  logic       reset;
  logic       sys_con;
  logic [3:0] br;
  logic       bbsy, vas, dtack, berr_in;

  logic [3:0] bg_p, bg_r;
  logic       bclr_p, bclr_r, berr_p, berr_r;
  logic [1:0] own_p, own_r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  vme_system_arbiter #(.ROUND_ROBIN(0), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)) dut_p (
    .clock(clock), .reset(reset), .sys_con(sys_con), .vme_bus_request(br),
    .vme_bbsy(bbsy), .vme_as(vas), .vme_dtack(dtack), .vme_berr_in(berr_in),
    .vme_bus_grant_out(bg_p), .vme_bclr(bclr_p), .vme_berr_out(berr_p),
    .owner_level(own_p));

  vme_system_arbiter #(.ROUND_ROBIN(1), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)) dut_r (
    .clock(clock), .reset(reset), .sys_con(sys_con), .vme_bus_request(br),
    .vme_bbsy(bbsy), .vme_as(vas), .vme_dtack(dtack), .vme_berr_in(berr_in),
    .vme_bus_grant_out(bg_r), .vme_bclr(bclr_r), .vme_berr_out(berr_r),
    .owner_level(own_r));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 = fixed priority, index 1 = round robin.
  // phase: 0 waiting for request, 1 granted, 2 bus owned, 3 chain settling.
  int         phase[2], age[2], last[2], own[2];
  logic [3:0] mbg[2];
  logic       mbclr[2];
  int         tcnt;
  logic       mberr;

  function automatic int pick(input int rr, input int lst, input logic [3:0] b);
    int r = 0;
    if (rr == 0) begin
      for (int j = 0; j < 4; j++) if (!b[j]) r = j;
    end else begin
      for (int k = 4; k >= 1; k--) if (!b[(lst + k) % 4]) r = (lst + k) % 4;
    end
    return r;
  endfunction

  function automatic bit higher_waiting(input int lst, input logic [3:0] b);
    for (int j = lst + 1; j < 4; j++) if (!b[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0; age[i] = 0; last[i] = 0; own[i] = 0;
      mbg[i] = F; mbclr[i] = 1'b1;
    end
    tcnt = 0; mberr = 1'b1;
  endtask

  task automatic fsm_step(input int i);
    case (phase[i])
      0: begin
        mbg[i] = F; mbclr[i] = 1'b1;
        if (br != F && bbsy) begin
          own[i] = pick(i, last[i], br);
          mbg[i] = F & ~(4'b0001 << own[i]);
          age[i] = 0; phase[i] = 1;
        end
      end
      1: begin
        if (!bbsy) begin
          mbg[i] = F; last[i] = own[i]; phase[i] = 2;
        end else if (br[own[i]] || age[i] == GT - 1) begin
          mbg[i] = F; phase[i] = 3;
        end
        age[i]++;
      end
      2: begin
        if (bbsy) begin mbclr[i] = 1'b1; phase[i] = 3; end
        else mbclr[i] = !(i == 0 && higher_waiting(last[i], br));
      end
      default: begin mbg[i] = F; phase[i] = 0; end
    endcase
  endtask

  task automatic timer_step();
    bit qual = !vas && dtack && berr_in;
    int old  = tcnt;
    if (!qual) tcnt = 0; else if (tcnt < BT - 1) tcnt++;
    if (vas) mberr = 1'b1;
    else if (qual && old == BT - 1) mberr = 1'b0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset || sys_con) model_clear();
    else begin
      fsm_step(0);
      fsm_step(1);
      timer_step();
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(posedge clock) begin
    #1;
    chk("bg_p",   bg_p,   mbg[0]);
    chk("bclr_p", bclr_p, mbclr[0]);
    chk("own_p",  own_p,  own[0]);
    chk("berr_p", berr_p, mberr);
    chk("bg_r",   bg_r,   mbg[1]);
    chk("bclr_r", bclr_r, mbclr[1]);
    chk("own_r",  own_r,  own[1]);
    chk("berr_r", berr_r, mberr);
    chk("bg_p_single", int'($countones(~bg_p) <= 1), 1);
    chk("bg_r_single", int'($countones(~bg_r) <= 1), 1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic nclk();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    sys_con = 1'b0; br = F; bbsy = 1'b1; vas = 1'b1; dtack = 1'b1; berr_in = 1'b1;
  endtask

  task automatic do_reset();
    nclk();
    idle_inputs();
    reset = 1'b0;
    nclk();
    nclk();
    reset = 1'b1;
  endtask

  task automatic wait_bg_p(input logic [3:0] v, input string nm);
    int n = 0;
    while (bg_p != v && n < 40) begin nclk(); n++; end
    if (bg_p != v) chk({nm, "_timeout"}, bg_p, v);
  endtask

  int exp_rr[5] = '{1, 2, 3, 0, 1};

  initial begin
    int n, g, hold, grants, lvl;
    bit saw;
    model_clear();
    idle_inputs();
    reset = 1'b0;
    nclk();
    nclk();
    chk("reset_bg",   bg_p, F);
    chk("reset_bclr", bclr_p, 1);
    chk("reset_berr", berr_p, 1);
    chk("reset_own",  own_r, 0);
    reset = 1'b1;

    // Fixed priority: levels 3 and 1 request, level 3 wins one clock later
    nclk();
    br = 4'b0101;
    nclk();
    chk("prio_bg3", bg_p, 4'b0111);
    chk("prio_own3", own_p, 3);
    bbsy = 1'b0;
    nclk();
    chk("prio_busy_bg", bg_p, F);
    br = 4'b1101;
    nclk();
    chk("prio_bclr_low_req", bclr_p, 1);
    bbsy = 1'b1;
    wait_bg_p(4'b1101, "prio_l1");
    chk("prio_own1", own_p, 1);
    bbsy = 1'b0;
    nclk();
    br = 4'b0101;
    nclk();
    chk("prio_bclr_high_req", bclr_p, 0);
    // sys_con taken high while busy releases bclr on the next edge
    sys_con = 1'b1;
    nclk();
    chk("syscon_bclr", bclr_p, 1);
    chk("syscon_own", own_p, 0);
    sys_con = 1'b0;

    // Round robin: everyone requests, each owner holds BBSY 3 clocks
    do_reset();
    br = 4'b0000;
    hold = 0; grants = 0; n = 0;
    while (grants < 5 && n < 200) begin
      nclk(); n++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) bbsy = 1'b1;
      end else if (bg_r != F) begin
        lvl = 0;
        for (int j = 0; j < 4; j++) if (!bg_r[j]) lvl = j;
        chk("rr_order", lvl, exp_rr[grants]);
        chk("rr_owner", own_r, lvl);
        grants++;
        bbsy = 1'b0;
        hold = 3;
      end
    end
    chk("rr_grant_count", grants, 5);

    // Grant timeout: level 2 requests, BBSY never answers
    do_reset();
    br = 4'b1011;
    wait_bg_p(4'b1011, "to_first");
    n = 1;
    while (n < 50) begin
      nclk();
      if (bg_p == 4'b1011) n++; else break;
    end
    chk("to_low_cycles", n, GT);
    g = 0;
    do begin g++; nclk(); end while (bg_p != 4'b1011 && g < 20);
    chk("to_gap_cycles", g, 2);

    // Requester withdraws two clocks into the grant
    do_reset();
    br = 4'b1110;
    wait_bg_p(4'b1110, "wd_first");
    nclk();
    br = F;
    nclk();
    chk("wd_release", bg_p, F);
    for (int k = 0; k < 3; k++) begin
      nclk();
      chk("wd_quiet", bg_p, F);
    end
    chk("wd_own", own_p, 0);

    // Bus timer fires 16 clocks into an unanswered strobe
    do_reset();
    vas = 1'b0;
    n = 0;
    while (berr_p && n < 40) begin nclk(); n++; end
    chk("bt_latency", n, BT);
    nclk();
    nclk();
    chk("bt_hold", berr_p, 0);
    vas = 1'b1;
    nclk();
    chk("bt_release", berr_p, 1);
    vas = 1'b0;
    saw = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 10) dtack = 1'b0;
      nclk();
      if (!berr_p) saw = 1'b1;
    end
    chk("bt_dtack_no_berr", saw, 0);
    vas = 1'b1; dtack = 1'b1;

    // Async reset during a grant releases BG without a clock edge
    do_reset();
    br = 4'b1101;
    wait_bg_p(4'b1101, "ar_grant");
    #2;
    reset = 1'b0;
    #1;
    chk("async_bg_p", bg_p, F);
    chk("async_bg_r", bg_r, F);
    nclk();
    reset = 1'b1;

    // Randomised traffic
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      nclk();
      if ($urandom_range(3) == 0) br = 4'($urandom);
      if ($urandom_range(3) == 0) bbsy = ~bbsy;
      if ($urandom_range(19) == 0) vas = ~vas;
      dtack   = ($urandom_range(39) != 0);
      berr_in = ($urandom_range(99) != 0);
      sys_con = ($urandom_range(199) == 0);
    end
    idle_inputs();
    nclk();
    nclk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
